// File: rtl/instr_sequencer_if.sv
// Bus bundle between the program sequencer, its program memory and the 9-bit core.
// master: the sequencer side (drives memory address/strobe and the core's DIN/run).
// slave:  the memory + core side (returns read data and the core's done).
interface instr_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [8:0]        mem_rdata;
  logic [8:0]        din;
  logic              run;
  logic              done;

  modport master (
    output mem_addr, mem_rd, din, run,
    input  mem_rdata, done
  );

  modport slave (
    input  mem_addr, mem_rd, din, run,
    output mem_rdata, done
  );
endinterface

// File: rtl/instr_sequencer.sv
// Program sequencer for the 9-bit processor core.
// Fetches instruction words from a synchronous program memory (1-cycle read latency),
// presents them on the core's DIN bus and holds `run` for the whole instruction.
// MVI prefetches its immediate word so it is on DIN from the core's step 1 onward.
// A RUN phase lasting TIMEOUT cycles without `done` aborts into HALTED with `err` set.
// TIMEOUT must be at least 4.
// Optional feature: define SEQ_STEP_EN to add the `step` input, which gates the move
// from LD_INS/LD_IMM into RUN (single-step debugging). HALT is never gated.
// Reset is synchronous and active-high.
module instr_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
`ifdef SEQ_STEP_EN
  input  logic              step,
`endif
  instr_sequencer_if.master bus,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_MVI  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    RD_INS,
    LD_INS,
    RD_IMM,
    LD_IMM,
    RUN,
    HALTED
  } state_t;

  state_t            state;
  logic [8:0]        ins_reg;
  logic [8:0]        imm_reg;
  logic [TW-1:0]     tmo_cnt;
  logic              ld_hold;
  logic [8:0]        cur_ins;
  logic              is_mvi;
  logic              step_ok;
  logic [ADDR_W-1:0] pc_next;

  // The instruction word under decode: fresh memory data on the first LD_INS cycle,
  // the already-captured copy while the step gate holds us in LD_INS.
  assign cur_ins = ld_hold ? ins_reg : bus.mem_rdata;
  assign is_mvi  = (ins_reg[8:6] == OP_MVI);
  assign pc_next = pc + (is_mvi ? ADDR_W'(2) : ADDR_W'(1));

`ifdef SEQ_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  // Status flags decode straight from the state register.
  assign busy   = (state != IDLE) && (state != HALTED);
  assign halted = (state == HALTED);

  // Sequencer FSM; every bus output is registered and set on the transition into the state that needs it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= '0;
      bus.mem_addr <= '0;
      bus.mem_rd   <= 1'b0;
      bus.din      <= '0;
      bus.run      <= 1'b0;
      err          <= 1'b0;
      ins_reg      <= '0;
      imm_reg      <= '0;
      tmo_cnt      <= '0;
      ld_hold      <= 1'b0;
    end else begin
      bus.mem_rd <= 1'b0;
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            state        <= RD_INS;
            pc           <= '0;
            err          <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_rd   <= 1'b1;
          end
        end
        RD_INS: begin
          state <= LD_INS;
        end
        LD_INS: begin
          if (!ld_hold) begin
            ins_reg <= bus.mem_rdata;
          end
          if (cur_ins[8:6] == OP_HALT) begin
            state   <= HALTED;
            ld_hold <= 1'b0;
          end else if (cur_ins[8:6] == OP_MVI) begin
            state        <= RD_IMM;
            bus.mem_addr <= pc + ADDR_W'(1);
            bus.mem_rd   <= 1'b1;
            ld_hold      <= 1'b0;
          end else if (step_ok) begin
            state   <= RUN;
            bus.run <= 1'b1;
            bus.din <= cur_ins;
            tmo_cnt <= TW'(1);
            ld_hold <= 1'b0;
          end else begin
            ld_hold <= 1'b1;
          end
        end
        RD_IMM: begin
          state <= LD_IMM;
        end
        LD_IMM: begin
          if (!ld_hold) begin
            imm_reg <= bus.mem_rdata;
          end
          if (step_ok) begin
            state   <= RUN;
            bus.run <= 1'b1;
            bus.din <= ins_reg;
            tmo_cnt <= TW'(1);
            ld_hold <= 1'b0;
          end else begin
            ld_hold <= 1'b1;
          end
        end
        RUN: begin
          if ((tmo_cnt != TW'(1)) && bus.done) begin
            state        <= RD_INS;
            pc           <= pc_next;
            bus.mem_addr <= pc_next;
            bus.mem_rd   <= 1'b1;
            bus.run      <= 1'b0;
          end else if (tmo_cnt == TW'(TIMEOUT)) begin
            state   <= HALTED;
            err     <= 1'b1;
            bus.run <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
            bus.din <= is_mvi ? imm_reg : ins_reg;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (ADDR_W=2, TIMEOUT=6).
// A 4-word program memory and a simple core model (done after core_len RUN cycles)
// surround the DUT; cycle numbers count from the cycle after start is sampled-driven.
module tb_instr_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       step;
  logic [1:0] pc;
  logic       busy;
  logic       halted;
  logic       err;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         core_len = 2;
  bit         core_en  = 1'b0;
  bit         done_force = 1'b0;
  int         run_cnt  = 0;
  logic [8:0] mem [0:3];

  instr_sequencer_if #(.ADDR_W(2)) bus ();

  instr_sequencer #(.ADDR_W(2), .TIMEOUT(6)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
`ifdef SEQ_STEP_EN
    .step   (step),
`endif
    .bus    (bus),
    .pc     (pc),
    .busy   (busy),
    .halted (halted),
    .err    (err)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Synchronous program memory: data valid one cycle after the read strobe.
  always @(posedge clock) begin
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Core model: counts RUN cycles and raises done combinationally on the last one.
  always @(posedge clock) begin
    if (!bus.run) run_cnt <= 0;
    else          run_cnt <= run_cnt + 1;
  end
  assign bus.done = done_force | (core_en & bus.run & (run_cnt == core_len - 1));

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; done_force = 1'b0;
    tick();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic do_start();
    start = 1'b1; cyc = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic load_mem(input logic [8:0] a, b, c, d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; step = 1'b1;
    bus.mem_rdata = 9'h1FF;
    load_mem(9'o012, 9'o700, 9'o000, 9'o000);
    tick(); tick();
    checks++; if (pc !== 2'd0) begin failures++; $display("[TB] FAIL reset_pc got=%0d exp=0", pc); end
    checks++; if ({busy, halted, err} !== 3'b000) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=000", {busy, halted, err}); end
    checks++; if ({bus.run, bus.mem_rd} !== 2'b00) begin failures++; $display("[TB] FAIL reset_run_rd got=%b exp=00", {bus.run, bus.mem_rd}); end
    checks++; if (bus.din !== 9'd0 || bus.mem_addr !== 2'd0) begin failures++; $display("[TB] FAIL reset_din_addr got=%h/%0d exp=000/0", bus.din, bus.mem_addr); end
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    load_mem(9'o430, 9'h05A, 9'o700, 9'o000);
    core_en = 1'b1; core_len = 3;
    do_start();
    tick_to(6);
    checks++; if (bus.run !== 1'b1 || bus.din !== 9'h05A) begin failures++; $display("[TB] FAIL midrun_pre got=run%b din%h exp=run1 din05a", bus.run, bus.din); end
    reset = 1'b1;
    tick();
    checks++; if ({bus.run, busy, err, halted} !== 4'b0000) begin failures++; $display("[TB] FAIL midrun_flags got=%b exp=0000", {bus.run, busy, err, halted}); end
    checks++; if (pc !== 2'd0 || bus.din !== 9'd0) begin failures++; $display("[TB] FAIL midrun_pc_din got=%0d/%h exp=0/000", pc, bus.din); end
    reset = 1'b0;
    tick_to(10);
    checks++; if (busy !== 1'b0 || bus.run !== 1'b0) begin failures++; $display("[TB] FAIL midrun_idle got=busy%b run%b exp=busy0 run0", busy, bus.run); end
  endtask

  task automatic test_basic();
    do_reset();
    load_mem(9'o012, 9'o700, 9'o000, 9'o000);
    core_en = 1'b1; core_len = 2;
    do_start();
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 2'd0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL basic_fetch0 got=rd%b addr%0d busy%b exp=rd1 addr0 busy1", bus.mem_rd, bus.mem_addr, busy); end
    tick_to(2);
    checks++; if (bus.run !== 1'b0 || bus.mem_rd !== 1'b0) begin failures++; $display("[TB] FAIL basic_ld got=run%b rd%b exp=run0 rd0", bus.run, bus.mem_rd); end
    tick_to(3);
    checks++; if (bus.run !== 1'b1 || bus.din !== 9'o012) begin failures++; $display("[TB] FAIL basic_run3 got=run%b din%o exp=run1 din012", bus.run, bus.din); end
    tick_to(4);
    checks++; if (bus.run !== 1'b1) begin failures++; $display("[TB] FAIL basic_run4 got=%b exp=1", bus.run); end
    tick_to(5);
    checks++; if (bus.run !== 1'b0 || bus.mem_rd !== 1'b1 || bus.mem_addr !== 2'd1 || pc !== 2'd1) begin failures++; $display("[TB] FAIL basic_fetch1 got=run%b rd%b addr%0d pc%0d exp=run0 rd1 addr1 pc1", bus.run, bus.mem_rd, bus.mem_addr, pc); end
    tick_to(7);
    checks++; if (halted !== 1'b1 || busy !== 1'b0 || pc !== 2'd1) begin failures++; $display("[TB] FAIL basic_halt got=h%b b%b pc%0d exp=h1 b0 pc1", halted, busy, pc); end
  endtask

  task automatic test_mvi();
    do_reset();
    load_mem(9'o430, 9'h05A, 9'o700, 9'o000);
    core_en = 1'b1; core_len = 2;
    do_start();
    tick_to(3);
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 2'd1) begin failures++; $display("[TB] FAIL mvi_rdimm got=rd%b addr%0d exp=rd1 addr1", bus.mem_rd, bus.mem_addr); end
    tick_to(4);
    checks++; if (bus.run !== 1'b0) begin failures++; $display("[TB] FAIL mvi_ldimm_run got=%b exp=0", bus.run); end
    tick_to(5);
    checks++; if (bus.run !== 1'b1 || bus.din !== 9'o430) begin failures++; $display("[TB] FAIL mvi_step0 got=run%b din%o exp=run1 din430", bus.run, bus.din); end
    tick_to(6);
    checks++; if (bus.din !== 9'h05A) begin failures++; $display("[TB] FAIL mvi_step1 got=%h exp=05a", bus.din); end
    tick_to(7);
    checks++; if (pc !== 2'd2 || bus.run !== 1'b0 || bus.mem_addr !== 2'd2) begin failures++; $display("[TB] FAIL mvi_pc got=pc%0d run%b addr%0d exp=pc2 run0 addr2", pc, bus.run, bus.mem_addr); end
    tick_to(9);
    checks++; if (halted !== 1'b1 || pc !== 2'd2) begin failures++; $display("[TB] FAIL mvi_halt got=h%b pc%0d exp=h1 pc2", halted, pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    load_mem(9'h011, 9'o012, 9'o012, 9'o430);
    core_en = 1'b1; core_len = 2;
    do_start();
    tick_to(13);
    checks++; if (pc !== 2'd3) begin failures++; $display("[TB] FAIL wrap_pc3 got=%0d exp=3", pc); end
    tick_to(15);
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 2'd0) begin failures++; $display("[TB] FAIL wrap_immaddr got=rd%b addr%0d exp=rd1 addr0", bus.mem_rd, bus.mem_addr); end
    tick_to(17);
    checks++; if (bus.run !== 1'b1 || bus.din !== 9'o430) begin failures++; $display("[TB] FAIL wrap_step0 got=run%b din%o exp=run1 din430", bus.run, bus.din); end
    tick_to(18);
    checks++; if (bus.din !== 9'h011) begin failures++; $display("[TB] FAIL wrap_step1 got=%h exp=011", bus.din); end
    tick_to(19);
    checks++; if (pc !== 2'd1 || bus.mem_addr !== 2'd1) begin failures++; $display("[TB] FAIL wrap_pcnext got=pc%0d addr%0d exp=pc1 addr1", pc, bus.mem_addr); end
  endtask

  task automatic test_timeout();
    do_reset();
    load_mem(9'o012, 9'o700, 9'o000, 9'o000);
    core_en = 1'b0;
    do_start();
    tick_to(8);
    checks++; if (bus.run !== 1'b1 || err !== 1'b0) begin failures++; $display("[TB] FAIL tmo_last got=run%b err%b exp=run1 err0", bus.run, err); end
    tick_to(9);
    checks++; if ({bus.run, err, halted} !== 3'b011 || pc !== 2'd0) begin failures++; $display("[TB] FAIL tmo_abort got=run%b err%b h%b pc%0d exp=run0 err1 h1 pc0", bus.run, err, halted, pc); end
    do_start();
    checks++; if (err !== 1'b0 || busy !== 1'b1 || halted !== 1'b0) begin failures++; $display("[TB] FAIL tmo_restart got=err%b busy%b h%b exp=err0 busy1 h0", err, busy, halted); end
    do_reset();
    core_en = 1'b1; core_len = 6;
    do_start();
    tick_to(9);
    checks++; if ({bus.run, err, halted} !== 3'b000 || pc !== 2'd1 || bus.mem_rd !== 1'b1) begin failures++; $display("[TB] FAIL tmo_donewins got=run%b err%b h%b pc%0d rd%b exp=run0 err0 h0 pc1 rd1", bus.run, err, halted, pc, bus.mem_rd); end
  endtask

  task automatic test_ignored();
    do_reset();
    load_mem(9'o012, 9'o700, 9'o000, 9'o000);
    core_en = 1'b0;
    done_force = 1'b1;
    tick();
    done_force = 1'b0;
    tick();
    checks++; if ({busy, err, bus.mem_rd} !== 3'b000 || pc !== 2'd0) begin failures++; $display("[TB] FAIL ign_idle got=busy%b err%b rd%b pc%0d exp=000 pc0", busy, err, bus.mem_rd, pc); end
    do_start();
    tick_to(3);
    done_force = 1'b1;
    tick();
    done_force = 1'b0;
    checks++; if (bus.run !== 1'b1 || pc !== 2'd0) begin failures++; $display("[TB] FAIL ign_first got=run%b pc%0d exp=run1 pc0", bus.run, pc); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (bus.run !== 1'b1 || busy !== 1'b1 || pc !== 2'd0 || bus.mem_rd !== 1'b0) begin failures++; $display("[TB] FAIL ign_start got=run%b busy%b pc%0d rd%b exp=run1 busy1 pc0 rd0", bus.run, busy, pc, bus.mem_rd); end
    done_force = 1'b1;
    tick();
    done_force = 1'b0;
    checks++; if (bus.run !== 1'b0 || pc !== 2'd1 || bus.mem_addr !== 2'd1) begin failures++; $display("[TB] FAIL ign_done3 got=run%b pc%0d addr%0d exp=run0 pc1 addr1", bus.run, pc, bus.mem_addr); end
  endtask

`ifdef SEQ_STEP_EN
  task automatic test_step();
    int run_seen;
    do_reset();
    load_mem(9'o012, 9'o700, 9'o000, 9'o000);
    core_en = 1'b1; core_len = 2;
    step = 1'b0;
    do_start();
    tick_to(2);
    run_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.run !== 1'b0) run_seen++;
    end
    checks++; if (run_seen !== 0) begin failures++; $display("[TB] FAIL step_hold got=%0d run cycles exp=0", run_seen); end
    step = 1'b1;
    tick();
    checks++; if (bus.run !== 1'b1 || bus.din !== 9'o012) begin failures++; $display("[TB] FAIL step_go got=run%b din%o exp=run1 din012", bus.run, bus.din); end
  endtask
`endif

  // Guard against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_reset_mid_run();
    test_basic();
    test_mvi();
    test_wrap();
    test_timeout();
    test_ignored();
`ifdef SEQ_STEP_EN
    test_step();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
